mem_load_return: RTL and testbench

- Load-return path of the data-memory port: the read-side counterpart of the store-side byte-lane steering logic.
- Tracks each load issued to the data port, selects the source (CPU BRAM, DIN mailbox, DIN status, unmapped) and extracts the addressed byte, halfword or word from the BRAM's byte-swapped storage.
- Sign- or zero-extends the result and delivers it to writeback after the BRAM read latency.
- Also owns the DIN input mailbox: a one-word register filled by an external producer through a valid/ready handshake and drained by core loads.

---
 rtl/mem_load_return.sv | 160 ++++++++++++++++
 tb/tb_mem_load_return.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_load_return.sv
// Load-return path of the data-memory port plus the DIN input mailbox.
// Optional misalignment trap: define MEM_LOAD_MISALIGN_TRAP_EN to add the loadMisalign output.
module mem_load_return #(
  parameter logic [1:0]  MEM_DISABLE    = 2'b00,
  parameter logic [1:0]  MEM_READ_SEXT  = 2'b01,
  parameter logic [1:0]  MEM_READ_ZEXT  = 2'b10,
  parameter logic [1:0]  MEM_WRITE      = 2'b11,
  parameter logic [1:0]  BYTE           = 2'b00,
  parameter logic [1:0]  HALFWORD       = 2'b01,
  parameter logic [1:0]  WORD           = 2'b10,
  parameter logic [31:0] CPU_BRAM_START = 32'h0000_0000,
  parameter logic [31:0] CPU_BRAM_END   = 32'h007F_FF00,
  parameter logic [31:0] DIN_REG        = 32'h0200_0000,
  parameter logic [31:0] DIN_STAT       = 32'h0200_0004,
  parameter int unsigned READ_LATENCY   = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [1:0]  memOp,
  input  logic [1:0]  memSize,
  input  logic [31:0] ramDout,
  input  logic [31:0] extDinData,
  input  logic        extDinValid,
  output logic        extDinReady,
  output logic [31:0] loadData,
  output logic        loadValid,
`ifdef MEM_LOAD_MISALIGN_TRAP_EN
  output logic        loadMisalign,
`endif
  output logic        dinFull
);

  typedef enum logic [1:0] {SRC_RAM, SRC_DIN, SRC_STAT, SRC_UNMAPPED} src_e;

  typedef struct packed {
    logic        valid;
    logic        sext;
    logic [1:0]  size;
    logic [1:0]  off;
    src_e        src;
    logic        mis;
    logic [31:0] snap;
  } stage_t;

  stage_t      pipe [READ_LATENCY];
  stage_t      issue;
  stage_t      fin;
  logic        is_load;
  logic        misalign;
  logic        pop;
  logic        accept;
  logic [31:0] din_word;
  logic [31:0] raw;
  logic [31:0] sel;

  always_comb begin
    is_load = 1'b0;
    case (memOp)
      MEM_READ_SEXT, MEM_READ_ZEXT: is_load = 1'b1;
      MEM_DISABLE, MEM_WRITE:       is_load = 1'b0;
      default:                      is_load = 1'b0;
    endcase
  end

  assign misalign = ((memSize == HALFWORD) && addr[0]) ||
                    ((memSize == WORD) && (addr[1:0] != 2'b00));

  always_comb begin
    issue       = '0;
    issue.valid = is_load;
    issue.sext  = (memOp == MEM_READ_SEXT);
    issue.size  = memSize;
    issue.off   = addr[1:0];
    issue.mis   = misalign;
    // Offset-based range test avoids a constant compare when the BRAM starts at 0.
    if ((addr - CPU_BRAM_START) <= (CPU_BRAM_END - CPU_BRAM_START)) begin
      issue.src = SRC_RAM;
    end else if (addr == DIN_REG) begin
      issue.src  = SRC_DIN;
      issue.snap = dinFull ? din_word : '0;
    end else if (addr == DIN_STAT) begin
      issue.src  = SRC_STAT;
      issue.snap = {31'b0, dinFull};
    end else begin
      issue.src = SRC_UNMAPPED;
    end
  end

`ifdef MEM_LOAD_MISALIGN_TRAP_EN
  assign pop = is_load && (issue.src == SRC_DIN) && dinFull && !misalign;
`else
  assign pop = is_load && (issue.src == SRC_DIN) && dinFull;
`endif

  assign extDinReady = !dinFull || pop;
  assign accept      = extDinValid && extDinReady;

  always_ff @(posedge clk) begin
    if (reset) begin
      dinFull  <= 1'b0;
      din_word <= '0;
    end else if (accept) begin
      dinFull  <= 1'b1;
      din_word <= extDinData;
    end else if (pop) begin
      dinFull  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < READ_LATENCY; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= issue;
      for (int unsigned i = 1; i < READ_LATENCY; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign fin = pipe[READ_LATENCY-1];
  assign raw = (fin.src == SRC_RAM) ? ramDout : fin.snap;

  // RAM words are stored byte-swapped; other sources are native words.
  always_comb begin
    sel = '0;
    if (fin.src == SRC_RAM) begin
      case (fin.size)
        BYTE: begin
          case (fin.off)
            2'd0:    sel = {24'b0, raw[31:24]};
            2'd1:    sel = {24'b0, raw[23:16]};
            2'd2:    sel = {24'b0, raw[15:8]};
            default: sel = {24'b0, raw[7:0]};
          endcase
        end
        HALFWORD: sel = fin.off[1] ? {16'b0, raw[7:0], raw[15:8]}
                                   : {16'b0, raw[23:16], raw[31:24]};
        default:  sel = {raw[7:0], raw[15:8], raw[23:16], raw[31:24]};
      endcase
    end else begin
      case (fin.size)
        BYTE:     sel = {24'b0, raw[7:0]};
        HALFWORD: sel = {16'b0, raw[15:0]};
        default:  sel = raw;
      endcase
    end
    if (fin.sext && (fin.size == BYTE))     sel[31:8]  = {24{sel[7]}};
    if (fin.sext && (fin.size == HALFWORD)) sel[31:16] = {16{sel[15]}};
  end

  assign loadValid = fin.valid;

`ifdef MEM_LOAD_MISALIGN_TRAP_EN
  assign loadMisalign = fin.valid && fin.mis;
  assign loadData     = (fin.valid && !fin.mis && (fin.src != SRC_UNMAPPED)) ? sel : '0;
`else
  assign loadData     = (fin.valid && (fin.src != SRC_UNMAPPED)) ? sel : '0;
`endif

endmodule

// File: tb/tb_mem_load_return.sv
// Directed bench for mem_load_return: latency-1 instance for data paths and mailbox,
// latency-2 instance for pipeline depth and reset flush.
module tb_mem_load_return;

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_SEXT = 2'b01;
  localparam logic [1:0] OP_ZEXT = 2'b10;
  localparam logic [1:0] OP_ST   = 2'b11;
  localparam logic [1:0] SZ_B    = 2'b00;
  localparam logic [1:0] SZ_H    = 2'b01;
  localparam logic [1:0] SZ_W    = 2'b10;
  localparam logic [31:0] A_DIN  = 32'h0200_0000;
  localparam logic [31:0] A_STAT = 32'h0200_0004;
  localparam logic [31:0] RAMW   = 32'h8899_AABB;

  logic        clk = 1'b0;
  logic        reset, reset2;
  logic [31:0] addr, ramDout, extDinData;
  logic [1:0]  memOp, memSize;
  logic        extDinValid;
  logic        extDinReady, loadValid, dinFull;
  logic [31:0] loadData;
  logic        extDinReady2, loadValid2, dinFull2;
  logic [31:0] loadData2;
`ifdef MEM_LOAD_MISALIGN_TRAP_EN
  logic        loadMisalign, loadMisalign2;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_load_return #(.READ_LATENCY(1)) dut (
    .clk(clk), .reset(reset), .addr(addr), .memOp(memOp), .memSize(memSize),
    .ramDout(ramDout), .extDinData(extDinData), .extDinValid(extDinValid),
    .extDinReady(extDinReady), .loadData(loadData), .loadValid(loadValid),
`ifdef MEM_LOAD_MISALIGN_TRAP_EN
    .loadMisalign(loadMisalign),
`endif
    .dinFull(dinFull)
  );

  mem_load_return #(.READ_LATENCY(2)) dut2 (
    .clk(clk), .reset(reset2), .addr(addr), .memOp(memOp), .memSize(memSize),
    .ramDout(ramDout), .extDinData(extDinData), .extDinValid(extDinValid),
    .extDinReady(extDinReady2), .loadData(loadData2), .loadValid(loadValid2),
`ifdef MEM_LOAD_MISALIGN_TRAP_EN
    .loadMisalign(loadMisalign2),
`endif
    .dinFull(dinFull2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic [1:0] sz, input logic [31:0] a);
    memOp   = op;
    memSize = sz;
    addr    = a;
  endtask

  // Issue one load, then in the return cycle present the BRAM word and check dut.
  task automatic load1(input string tag, input logic [1:0] op, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] word, input logic [31:0] exp);
    drive(op, sz, a);
    tick();
    drive(OP_NONE, SZ_W, 32'h0);
    ramDout = word;
    #1;
    check({tag, "_valid"}, {31'b0, loadValid}, 32'd1);
    check(tag, loadData, exp);
  endtask

  task automatic push(input logic [31:0] d);
    extDinData  = d;
    extDinValid = 1'b1;
    tick();
    extDinValid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; reset2 = 1'b1;
    drive(OP_NONE, SZ_W, 32'h0);
    ramDout = '0; extDinData = '0; extDinValid = 1'b0;
    tick(); tick();
    reset = 1'b0; reset2 = 1'b0;
    #1;
    check("rst_valid", {31'b0, loadValid}, 32'd0);
    check("rst_data", loadData, 32'h0);
    check("rst_full", {31'b0, dinFull}, 32'd0);
    check("rst_ready", {31'b0, extDinReady}, 32'd1);

    load1("lb_sext", OP_SEXT, SZ_B, 32'h100, RAMW, 32'hFFFF_FF88);
    load1("lbu_3",   OP_ZEXT, SZ_B, 32'h103, RAMW, 32'h0000_00BB);
    load1("lh_sext", OP_SEXT, SZ_H, 32'h100, RAMW, 32'hFFFF_9988);
    load1("lhu_2",   OP_ZEXT, SZ_H, 32'h102, RAMW, 32'h0000_BBAA);
    load1("lw",      OP_SEXT, SZ_W, 32'h100, RAMW, 32'hBBAA_9988);

    // Back-to-back: LW, LBU, store, LW
    drive(OP_SEXT, SZ_W, 32'h100);
    tick();
    drive(OP_ZEXT, SZ_B, 32'h101); ramDout = RAMW; #1;
    check("b2b0_valid", {31'b0, loadValid}, 32'd1);
    check("b2b0_data", loadData, 32'hBBAA_9988);
    tick();
    drive(OP_ST, SZ_W, 32'h100); #1;
    check("b2b1_valid", {31'b0, loadValid}, 32'd1);
    check("b2b1_data", loadData, 32'h0000_0099);
    tick();
    drive(OP_SEXT, SZ_W, 32'h0050_0000); #1;
    check("b2b2_valid", {31'b0, loadValid}, 32'd0);
    check("b2b2_data", loadData, 32'h0);
    tick();
    drive(OP_NONE, SZ_W, 32'h0); ramDout = 32'h1122_3344; #1;
    check("b2b3_valid", {31'b0, loadValid}, 32'd1);
    check("b2b3_data", loadData, 32'h4433_2211);
    tick(); #1;
    check("idle_valid", {31'b0, loadValid}, 32'd0);

    // Mailbox fill, status, drain, empty read
    push(32'h1234_5678); #1;
    check("mb_full", {31'b0, dinFull}, 32'd1);
    check("mb_ready", {31'b0, extDinReady}, 32'd0);
    load1("mb_stat", OP_ZEXT, SZ_W, A_STAT, 32'hDEAD_BEEF, 32'h0000_0001);
    load1("mb_pop", OP_ZEXT, SZ_W, A_DIN, 32'hDEAD_BEEF, 32'h1234_5678);
    check("mb_empty", {31'b0, dinFull}, 32'd0);
    load1("mb_pop_empty", OP_ZEXT, SZ_W, A_DIN, 32'hDEAD_BEEF, 32'h0);
    load1("mb_stat0", OP_ZEXT, SZ_W, A_STAT, 32'hDEAD_BEEF, 32'h0);

    // Simultaneous pop and push
    push(32'hAAAA_0001);
    drive(OP_ZEXT, SZ_W, A_DIN);
    extDinData = 32'hBBBB_0002; extDinValid = 1'b1; #1;
    check("pp_ready", {31'b0, extDinReady}, 32'd1);
    tick();
    drive(OP_NONE, SZ_W, 32'h0); extDinValid = 1'b0; #1;
    check("pp_data", loadData, 32'hAAAA_0001);
    check("pp_full", {31'b0, dinFull}, 32'd1);
    load1("pp_next", OP_ZEXT, SZ_W, A_DIN, 32'h0, 32'hBBBB_0002);
    check("pp_empty", {31'b0, dinFull}, 32'd0);

    // Unmapped
    load1("unmapped", OP_SEXT, SZ_W, 32'h0300_0000, 32'hFFFF_FFFF, 32'h0);
    // Sign-extended byte from the mailbox uses native byte 0
    push(32'h0000_0080);
    load1("mb_lb_sext", OP_SEXT, SZ_B, A_DIN, 32'h0, 32'hFFFF_FF80);

    // Latency-2 instance: valid only at N+2
    push(32'h0000_0055);
    drive(OP_SEXT, SZ_W, 32'h100);
    tick();
    drive(OP_NONE, SZ_W, 32'h0); #1;
    check("l2_early", {31'b0, loadValid2}, 32'd0);
    tick();
    ramDout = RAMW; #1;
    check("l2_valid", {31'b0, loadValid2}, 32'd1);
    check("l2_data", loadData2, 32'hBBAA_9988);

    // Reset with a load in flight on the latency-2 instance
    tick();
    check("l2_full_pre", {31'b0, dinFull2}, 32'd1);
    drive(OP_SEXT, SZ_W, 32'h100);
    tick();
    drive(OP_NONE, SZ_W, 32'h0); reset2 = 1'b1;
    tick();
    reset2 = 1'b0; #1;
    check("l2_flush_valid", {31'b0, loadValid2}, 32'd0);
    check("l2_flush_data", loadData2, 32'h0);
    check("l2_rst_full", {31'b0, dinFull2}, 32'd0);
    check("l2_rst_ready", {31'b0, extDinReady2}, 32'd1);
    tick(); #1;
    check("l2_after_valid", {31'b0, loadValid2}, 32'd0);

`ifdef MEM_LOAD_MISALIGN_TRAP_EN
    load1("mis_lh", OP_SEXT, SZ_H, 32'h101, RAMW, 32'h0);
    check("mis_lh_flag", {31'b0, loadMisalign}, 32'd1);
    load1("mis_din", OP_ZEXT, SZ_W, A_DIN + 32'd1, RAMW, 32'h0);
    check("mis_din_flag", {31'b0, loadMisalign}, 32'd1);
    check("mis_din_full", {31'b0, dinFull}, 32'd1);
    load1("ok_lw", OP_ZEXT, SZ_W, 32'h100, RAMW, 32'hBBAA_9988);
    check("ok_lw_flag", {31'b0, loadMisalign}, 32'd0);
`else
    load1("mis_lhu", OP_ZEXT, SZ_H, 32'h101, RAMW, 32'h0000_9988);
    load1("mis_lw", OP_ZEXT, SZ_W, 32'h103, RAMW, 32'hBBAA_9988);
    load1("mis_lh3", OP_SEXT, SZ_H, 32'h103, RAMW, 32'hFFFF_BBAA);
`endif
    load1("final_pop", OP_ZEXT, SZ_W, A_DIN, 32'h0, 32'h0000_0055);
    check("final_empty", {31'b0, dinFull}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
